control_muestreo: RTL and testbench
===================================

CONTROL_MUESTREO -- requirements
Module: control_muestreo

Interface
REQ-001 SHALL have parameter PERIODO, default 100: idle cycles between acquisitions, legal range 2..65535.
REQ-002 SHALL have parameter TIMEOUT, default 32: maximum cycles to wait for done_in after start, legal range 2..255.
REQ-003 SHALL have port Clock_Muestreo  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  level; permits a new acquisition to begin.
REQ-006 SHALL have port done_in  input  1  single-cycle pulse from the serial ADC capture stage; dato_in is valid in the same cycle.
REQ-007 SHALL have port dato_in  input  12  converted sample from the ADC capture stage.
REQ-008 SHALL have port start  output  1  registered single-cycle request to the ADC capture stage.
REQ-009 SHALL have port muestra  output  12  last accepted raw sample.
REQ-010 SHALL have port promedio  output  12  8-sample moving average.
REQ-011 SHALL have port promedio_valido  output  1  single-cycle pulse: promedio updated and window full.
REQ-012 SHALL have port error_timeout  output  1  single-cycle pulse: an acquisition timed out.
REQ-013 SHALL have port error_sticky  output  1  set by any timeout; cleared only by reset.

Function
REQ-014 SHALL implement FSM states ESPERA, SOLICITAR, AGUARDAR, ACUMULAR.
REQ-015 ESPERA: 16-bit period counter increments while enable=1; held at 0 while enable=0; at count PERIODO-1 clear counter, go SOLICITAR.
REQ-016 SOLICITAR: lasts exactly 1 cycle; start=1 in the following cycle only (registered); clear timeout counter; go AGUARDAR.
REQ-017 AGUARDAR: if done_in=1, latch dato_in into internal sample register and muestra, go ACUMULAR.
REQ-018 AGUARDAR: otherwise 8-bit timeout counter increments; at count TIMEOUT-1 without done_in: error_timeout=1 for the next cycle, set error_sticky, go ESPERA, sample discarded, buffer/sum/pointer unchanged.
REQ-019 Simultaneous done_in and timeout terminal count SHALL be treated as done (sample accepted, no error).
REQ-020 done_in outside AGUARDAR SHALL be ignored (no register changes).
REQ-021 ACUMULAR: 1 cycle; write sample to 8x12 circular buffer at 3-bit write pointer; sum_next = sum - buf[ptr] + sample (15-bit, never overflows); ptr wraps 7->0; fill counter saturates at 8; go ESPERA.
REQ-022 promedio SHALL be registered as sum_next[14:3] (truncating divide by 8) at the end of ACUMULAR, visible the following cycle.
REQ-023 promedio_valido SHALL pulse 1 cycle together with the promedio update only when the fill counter (after increment) equals 8; first 7 samples update promedio without the pulse.
REQ-024 enable dropping mid-acquisition (SOLICITAR/AGUARDAR/ACUMULAR) SHALL NOT abort it; block completes and then holds in ESPERA.
REQ-025 Cycles per successful acquisition SHALL be PERIODO + 1 + k + 1, where k is the cycles from entering AGUARDAR to done_in (k>=1).
REQ-026 Unknown FSM encodings SHALL return to ESPERA.

Reset
REQ-027 reset SHALL asynchronously force: state ESPERA, all counters 0, ptr 0, fill 0, sum 0, all buffer entries 0.
REQ-028 reset values SHALL be: start 0, muestra 0, promedio 0, promedio_valido 0, error_timeout 0, error_sticky 0.
REQ-029 reset asserted mid-acquisition SHALL discard the pending sample; first start after release follows exactly PERIODO enabled cycles.

Verification
REQ-030 PERIODO=4, enable=1 from reset release, done_in 17 cycles after each start with dato_in=0x800 -> start pulses every 24 cycles; 8th sample gives promedio=0x800 with promedio_valido=1; samples 1..7 show no valid pulse.
REQ-031 Window wrap: samples 0x008 x8 then 0xFF8 x8 -> promedio steps (0x008*(8-n)+0xFF8*n)>>3 each sample, valid every sample after the 8th, final 0xFF8.
REQ-032 No done_in, TIMEOUT=32 -> error_timeout pulse 32 cycles after entering AGUARDAR, error_sticky=1, promedio unchanged, next start after PERIODO cycles.
REQ-033 done_in in the same cycle as timeout terminal count -> sample accepted, error_timeout=0, error_sticky unchanged.
REQ-034 enable=0 during AGUARDAR -> acquisition completes, promedio updated, no further start until enable=1; stray done_in in ESPERA changes nothing.
REQ-035 reset pulse during AGUARDAR after 5 accepted samples -> all outputs 0, fill restarts; promedio_valido first reappears on the 8th post-reset sample.

Source files
------------

// File: rtl/control_muestreo.sv
// Periodic ADC acquisition sequencer with timeout supervision
// and an 8-sample moving average of the accepted samples.
module control_muestreo #(
    parameter int PERIODO = 100,
    parameter int TIMEOUT = 32
) (
    input  logic        Clock_Muestreo,
    input  logic        reset,
    input  logic        enable,
    input  logic        done_in,
    input  logic [11:0] dato_in,
    output logic        start,
    output logic [11:0] muestra,
    output logic [11:0] promedio,
    output logic        promedio_valido,
    output logic        error_timeout,
    output logic        error_sticky
);

    typedef enum logic [1:0] {
        ESPERA    = 2'd0,
        SOLICITAR = 2'd1,
        AGUARDAR  = 2'd2,
        ACUMULAR  = 2'd3
    } estado_t;

    localparam logic [15:0] PER_FIN = 16'(PERIODO - 1);
    localparam logic [7:0]  TO_FIN  = 8'(TIMEOUT - 1);

    estado_t     estado;
    logic [15:0] cnt_periodo;
    logic [7:0]  cnt_timeout;
    logic [11:0] ventana [8];
    logic [2:0]  ptr;
    logic [3:0]  llenado;
    logic [14:0] suma;
    logic [14:0] suma_next;
    logic [3:0]  llenado_next;

    // Running sum with the oldest window entry swapped for the new sample
    always_comb begin
        suma_next    = suma - {3'b000, ventana[ptr]} + {3'b000, muestra};
        llenado_next = (llenado == 4'd8) ? 4'd8 : llenado + 4'd1;
    end

    // Acquisition sequencer, averaging window and registered outputs
    always_ff @(posedge Clock_Muestreo or posedge reset) begin
        if (reset) begin
            estado          <= ESPERA;
            cnt_periodo     <= '0;
            cnt_timeout     <= '0;
            ptr             <= '0;
            llenado         <= '0;
            suma            <= '0;
            start           <= 1'b0;
            muestra         <= '0;
            promedio        <= '0;
            promedio_valido <= 1'b0;
            error_timeout   <= 1'b0;
            error_sticky    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                ventana[i] <= '0;
            end
        end else begin
            start           <= 1'b0;
            promedio_valido <= 1'b0;
            error_timeout   <= 1'b0;
            case (estado)
                ESPERA: begin
                    if (!enable) begin
                        cnt_periodo <= '0;
                    end else if (cnt_periodo == PER_FIN) begin
                        cnt_periodo <= '0;
                        estado      <= SOLICITAR;
                    end else begin
                        cnt_periodo <= cnt_periodo + 16'd1;
                    end
                end
                SOLICITAR: begin
                    start       <= 1'b1;
                    cnt_timeout <= '0;
                    estado      <= AGUARDAR;
                end
                AGUARDAR: begin
                    // done_in wins over a coincident terminal count
                    if (done_in) begin
                        muestra <= dato_in;
                        estado  <= ACUMULAR;
                    end else if (cnt_timeout == TO_FIN) begin
                        error_timeout <= 1'b1;
                        error_sticky  <= 1'b1;
                        estado        <= ESPERA;
                    end else begin
                        cnt_timeout <= cnt_timeout + 8'd1;
                    end
                end
                ACUMULAR: begin
                    ventana[ptr]    <= muestra;
                    suma            <= suma_next;
                    ptr             <= ptr + 3'd1;
                    llenado         <= llenado_next;
                    promedio        <= suma_next[14:3];
                    promedio_valido <= (llenado_next == 4'd8);
                    estado          <= ESPERA;
                end
                default: begin
                    cnt_periodo <= '0;
                    estado      <= ESPERA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_muestreo.sv
// Randomized self-checking bench for control_muestreo against
// a queue-based moving-average and timing reference model.
module tb_control_muestreo;

    localparam int PER = 4;
    localparam int TO  = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        done_in;
    logic [11:0] dato_in;
    logic        start;
    logic [11:0] muestra;
    logic [11:0] promedio;
    logic        promedio_valido;
    logic        error_timeout;
    logic        error_sticky;

    int n_tests = 0;
    int n_fail  = 0;

    int win[$];
    int nacc;

    control_muestreo #(
        .PERIODO(PER),
        .TIMEOUT(TO)
    ) dut (
        .Clock_Muestreo (clk),
        .reset          (reset),
        .enable         (enable),
        .done_in        (done_in),
        .dato_in        (dato_in),
        .start          (start),
        .muestra        (muestra),
        .promedio       (promedio),
        .promedio_valido(promedio_valido),
        .error_timeout  (error_timeout),
        .error_sticky   (error_sticky)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        win.delete();
        nacc = 0;
    endfunction

    function automatic void model_push(input logic [11:0] d);
        win.push_back(int'(d));
        if (win.size() > 8) void'(win.pop_front());
        nacc++;
    endfunction

    function automatic logic [11:0] model_avg();
        int s = 0;
        foreach (win[i]) s += win[i];
        return 12'(s / 8);
    endfunction

    function automatic logic model_valid();
        return nacc >= 8;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        done_in = 1'b0;
        dato_in = '0;
        enable  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // Counts negedges until start is seen, bounded
    task automatic wait_start(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if (start === 1'b1) ok = 1'b1;
        end
    endtask

    // Called at the negedge where start is seen; done_in on AGUARDAR cycle k
    task automatic acq(input int k, input logic [11:0] d,
                       output logic [11:0] m, output logic [11:0] p,
                       output logic v, output logic e);
        repeat (k - 1) @(negedge clk);
        done_in = 1'b1;
        dato_in = d;
        @(negedge clk);
        done_in = 1'b0;
        dato_in = 12'($urandom);
        m = muestra;
        e = error_timeout;
        @(negedge clk);
        p = promedio;
        v = promedio_valido;
    endtask

    task automatic test_reset();
        int n;
        bit ok;
        n_tests++;
        if ({start, muestra, promedio, promedio_valido,
             error_timeout, error_sticky} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b %h %h %b %b %b want all 0",
                     start, muestra, promedio, promedio_valido,
                     error_timeout, error_sticky);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        wait_start(n, ok);
        n_tests++;
        if (!ok || n != PER + 1) begin
            n_fail++;
            $display("FAIL reset_first_start got %0d ok=%0d want %0d", n, ok, PER + 1);
        end
    endtask

    task automatic test_basic();
        logic [11:0] m, p;
        logic v, e;
        int n;
        bit ok;
        do_reset();
        wait_start(n, ok);
        for (int i = 0; i < 8; i++) begin
            acq(18, 12'h800, m, p, v, e);
            model_push(12'h800);
            n_tests++;
            if (m !== 12'h800 || p !== model_avg() || v !== (i == 7) || e !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_sample%0d got m=%h p=%h v=%b e=%b want m=800 p=%h v=%b e=0",
                         i, m, p, v, e, model_avg(), (i == 7));
            end
            wait_start(n, ok);
            n_tests++;
            if (!ok || 18 + 1 + n != 24) begin
                n_fail++;
                $display("FAIL basic_period got %0d want 24", 18 + 1 + n);
            end
        end
        n_tests++;
        if (promedio !== 12'h800) begin
            n_fail++;
            $display("FAIL basic_final got %h want 800", promedio);
        end
    endtask

    task automatic test_window_wrap();
        logic [11:0] m, p, d;
        logic v, e;
        int n;
        bit ok;
        do_reset();
        wait_start(n, ok);
        for (int i = 0; i < 16; i++) begin
            d = (i < 8) ? 12'h008 : 12'hFF8;
            acq(int'($urandom_range(1, 10)), d, m, p, v, e);
            model_push(d);
            n_tests++;
            if (p !== model_avg() || v !== model_valid()) begin
                n_fail++;
                $display("FAIL wrap_step%0d got p=%h v=%b want p=%h v=%b",
                         i, p, v, model_avg(), model_valid());
            end
            wait_start(n, ok);
        end
        n_tests++;
        if (promedio !== 12'hFF8) begin
            n_fail++;
            $display("FAIL wrap_final got %h want ff8", promedio);
        end
    endtask

    task automatic test_random();
        logic [11:0] m, p, d;
        logic v, e;
        int n, k;
        bit ok;
        for (int i = 0; i < 20; i++) begin
            k = int'($urandom_range(1, TO));
            d = 12'($urandom);
            acq(k, d, m, p, v, e);
            model_push(d);
            n_tests++;
            if (m !== d || p !== model_avg() || v !== model_valid() || e !== 1'b0) begin
                n_fail++;
                $display("FAIL random%0d k=%0d got m=%h p=%h v=%b e=%b want m=%h p=%h v=%b e=0",
                         i, k, m, p, v, e, d, model_avg(), model_valid());
            end
            wait_start(n, ok);
            n_tests++;
            if (!ok || n != PER + 1) begin
                n_fail++;
                $display("FAIL random_period%0d got %0d want %0d", i, n, PER + 1);
            end
        end
    endtask

    task automatic test_timeout();
        logic [11:0] m, p, d, p0, m0;
        logic v, e;
        bit early;
        int n;
        bit ok;
        p0 = promedio;
        m0 = muestra;
        early = 1'b0;
        for (int i = 1; i < TO; i++) begin
            @(negedge clk);
            if (error_timeout !== 1'b0) early = 1'b1;
        end
        @(negedge clk);
        n_tests++;
        if (early || error_timeout !== 1'b1 || error_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_pulse got early=%b et=%b es=%b want 0 1 1",
                     early, error_timeout, error_sticky);
        end
        n_tests++;
        if (promedio !== p0 || muestra !== m0 || promedio_valido !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_hold got p=%h m=%h v=%b want p=%h m=%h v=0",
                     promedio, muestra, promedio_valido, p0, m0);
        end
        @(negedge clk);
        n_tests++;
        if (error_timeout !== 1'b0 || error_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_width got et=%b es=%b want 0 1",
                     error_timeout, error_sticky);
        end
        wait_start(n, ok);
        n_tests++;
        if (!ok || n != PER) begin
            n_fail++;
            $display("FAIL timeout_restart got %0d want %0d", n, PER);
        end
        d = 12'($urandom);
        acq(int'($urandom_range(1, 20)), d, m, p, v, e);
        model_push(d);
        n_tests++;
        if (p !== model_avg() || v !== model_valid()) begin
            n_fail++;
            $display("FAIL timeout_after got p=%h v=%b want p=%h v=%b",
                     p, v, model_avg(), model_valid());
        end
        wait_start(n, ok);
    endtask

    task automatic test_timeout_edge();
        logic [11:0] m, p, d;
        logic v, e;
        int n;
        bit ok;
        d = 12'($urandom);
        acq(TO, d, m, p, v, e);
        model_push(d);
        n_tests++;
        if (e !== 1'b0 || m !== d || p !== model_avg() || error_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL edge_done got e=%b m=%h p=%h es=%b want 0 %h %h 1",
                     e, m, p, error_sticky, d, model_avg());
        end
        wait_start(n, ok);
        n_tests++;
        if (!ok || n != PER + 1) begin
            n_fail++;
            $display("FAIL edge_restart got %0d want %0d", n, PER + 1);
        end
    endtask

    task automatic test_enable_drop();
        logic [11:0] m, p, d;
        logic v, e;
        int n, starts;
        bit ok;
        enable = 1'b0;
        d = 12'($urandom);
        acq(int'($urandom_range(1, 20)), d, m, p, v, e);
        model_push(d);
        n_tests++;
        if (m !== d || p !== model_avg()) begin
            n_fail++;
            $display("FAIL drop_complete got m=%h p=%h want %h %h", m, p, d, model_avg());
        end
        starts = 0;
        for (int i = 0; i < 30; i++) begin
            done_in = (i % 7 == 3);
            dato_in = 12'($urandom);
            @(negedge clk);
            if (start === 1'b1) starts++;
        end
        done_in = 1'b0;
        n_tests++;
        if (starts != 0 || muestra !== d || promedio !== model_avg()) begin
            n_fail++;
            $display("FAIL drop_idle got starts=%0d m=%h p=%h want 0 %h %h",
                     starts, muestra, promedio, d, model_avg());
        end
        enable = 1'b1;
        wait_start(n, ok);
        n_tests++;
        if (!ok || n != PER + 1) begin
            n_fail++;
            $display("FAIL drop_resume got %0d want %0d", n, PER + 1);
        end
        d = 12'($urandom);
        acq(int'($urandom_range(1, 20)), d, m, p, v, e);
        model_push(d);
        n_tests++;
        if (p !== model_avg() || v !== model_valid()) begin
            n_fail++;
            $display("FAIL drop_after got p=%h v=%b want %h %b",
                     p, v, model_avg(), model_valid());
        end
        wait_start(n, ok);
    endtask

    task automatic test_reset_mid();
        logic [11:0] m, p, d;
        logic v, e;
        int n;
        bit ok;
        do_reset();
        wait_start(n, ok);
        for (int i = 0; i < 5; i++) begin
            d = 12'($urandom);
            acq(int'($urandom_range(1, 20)), d, m, p, v, e);
            model_push(d);
            wait_start(n, ok);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        n_tests++;
        if ({start, muestra, promedio, promedio_valido,
             error_timeout, error_sticky} !== 28'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs got %b %h %h %b %b %b want all 0",
                     start, muestra, promedio, promedio_valido,
                     error_timeout, error_sticky);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        wait_start(n, ok);
        n_tests++;
        if (!ok || n != PER + 1) begin
            n_fail++;
            $display("FAIL midreset_first_start got %0d want %0d", n, PER + 1);
        end
        for (int i = 0; i < 8; i++) begin
            d = 12'($urandom);
            acq(int'($urandom_range(1, 20)), d, m, p, v, e);
            model_push(d);
            n_tests++;
            if (v !== (i == 7) || p !== model_avg()) begin
                n_fail++;
                $display("FAIL midreset_sample%0d got p=%h v=%b want %h %b",
                         i, p, v, model_avg(), (i == 7));
            end
            wait_start(n, ok);
        end
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        done_in = 1'b0;
        dato_in = '0;
        model_clear();
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_window_wrap();
        test_random();
        test_timeout();
        test_timeout_edge();
        test_enable_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
